// File: rtl/tea_pkg.sv
// tea_pkg -- definitions shared by the TEA encrypt and decrypt blocks.
//   DELTA          : TEA key-schedule constant
//   DEFAULT_ROUNDS : number of full Feistel pairs used by default
//   tea_state_e    : IDLE / RUN / DONE control states
//   tea_data_t     : 64-bit block, [63:32]=v0, [31:0]=v1
//   tea_key_t      : 128-bit key, [127:96]=k0 .. [31:0]=k3
//   tea_mix()      : the F-function ((v<<4)+ka) ^ (v+sum) ^ ((v>>5)+kb)
package tea_pkg;

  localparam logic [31:0] DELTA          = 32'h9E3779B9;
  localparam int          DEFAULT_ROUNDS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tea_state_e;

  typedef logic [63:0]  tea_data_t;
  typedef logic [127:0] tea_key_t;

  // One half-round mixing term; all arithmetic wraps at 32 bits, shifts are logical.
  function automatic logic [31:0] tea_mix(input logic [31:0] v,
                                          input logic [31:0] sum,
                                          input logic [31:0] ka,
                                          input logic [31:0] kb);
    return ((v << 3'd4) + ka) ^ (v + sum) ^ ((v >> 3'd5) + kb);
  endfunction

endpackage

// File: rtl/tea_inv_round.sv
// tea_inv_round -- one combinational TEA decryption cycle (a full Feistel pair).
//   idata : current {v0,v1}
//   sum   : key-schedule sum for this cycle
//   key   : {k0,k1,k2,k3}
//   odata : {v0',v1'} after undoing one encryption cycle
module tea_inv_round
  import tea_pkg::*;
(
  input  tea_data_t   idata,
  input  logic [31:0] sum,
  input  tea_key_t    key,
  output tea_data_t   odata
);

  logic [31:0] v0;
  logic [31:0] v1;
  logic [31:0] v1_new;
  logic [31:0] v0_new;

  assign v0 = idata[63:32];
  assign v1 = idata[31:0];

  // v1 is undone first; the v0 step must see the already-updated v1.
  assign v1_new = v1 - tea_mix(v0, sum, key[63:32], key[31:0]);
  assign v0_new = v0 - tea_mix(v1_new, sum, key[127:96], key[95:64]);

  assign odata = {v0_new, v1_new};

endmodule

// File: rtl/tea_decrypt.sv
// tea_decrypt -- iterative TEA block decryptor, one Feistel pair per clock.
//   clk, rst         : clock, asynchronous active-high reset
//   in_valid/in_ready: ciphertext handshake (in_ready only in IDLE)
//   idata, key       : ciphertext {v0,v1} and 128-bit key, captured on accept
//   out_valid/out_ready : plaintext handshake (out_valid only in DONE)
//   odata            : plaintext {v0,v1}
//   busy             : block in flight (RUN or DONE)
module tea_decrypt
  import tea_pkg::*;
#(
  parameter int ROUNDS = DEFAULT_ROUNDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   idata,
  input  logic [127:0]  key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   odata,
  output logic          busy
);

  localparam int             CW       = $clog2(ROUNDS) + 1;
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(ROUNDS - 1);
  // Decryption walks the sum schedule backwards from DELTA*ROUNDS (mod 2^32).
  localparam logic [31:0]    SUM_INIT = DELTA * 32'(ROUNDS);

  tea_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  tea_data_t     data_q,  data_d;
  logic [31:0]   sum_q,   sum_d;
  tea_key_t      key_q,   key_d;
  tea_data_t     round_out;

  tea_inv_round u_round (
    .idata (data_q),
    .sum   (sum_q),
    .key   (key_q),
    .odata (round_out)
  );

  // Next-state logic: capture on accept, one round per RUN cycle, release on handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sum_d   = sum_q;
    key_d   = key_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          data_d  = idata;
          key_d   = key;
          sum_d   = SUM_INIT;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        data_d = round_out;
        sum_d  = sum_q - DELTA;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        // Returning to IDLE here means a new block can only be taken on the next edge.
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything including the key copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      data_q  <= 64'd0;
      sum_q   <= 32'd0;
      key_q   <= 128'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      key_q   <= key_d;
    end
  end

  // Outputs decode registered state only; rst gating keeps in_ready low during reset.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign odata     = data_q;

endmodule

// File: doc/tea_decrypt.md
TEA_DECRYPT -- requirements
Module: tea_decrypt

Interface
REQ-001 Parameter: ROUNDS, 32, number of decryption cycles (full Feistel pairs); legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  idata/key valid this cycle.
REQ-005 in_ready  output  1  block can accept a block; high only in IDLE.
REQ-006 idata  input  64  ciphertext, [63:32]=v0, [31:0]=v1.
REQ-007 key  input  128  key, [127:96]=k0, [95:64]=k1, [63:32]=k2, [31:0]=k3.
REQ-008 out_valid  output  1  odata holds plaintext; high only in DONE.
REQ-009 out_ready  input  1  consumer accepts odata this cycle.
REQ-010 odata  output  64  plaintext, same v0/v1 packing as idata.
REQ-011 busy  output  1  high in RUN or DONE.

Function
REQ-012 FSM states IDLE, RUN, DONE; IDLE->RUN on in_valid&&in_ready; RUN->DONE when round counter reaches ROUNDS-1; DONE->IDLE on out_valid&&out_ready.
REQ-013 On accept: latch v0, v1, key into internal registers; load sum = DELTA*ROUNDS mod 2^32 (0xC6EF3720 for ROUNDS=32); clear counter.
REQ-014 Each RUN cycle: v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3); then, using the new v1, v0 -= ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1); sum -= DELTA; counter += 1.
REQ-015 All arithmetic modulo 2^32; shifts logical; no saturation.
REQ-016 Latency: accept edge at cycle 0 -> out_valid high from cycle ROUNDS through the handshake cycle (32 cycles for default).
REQ-017 odata = {v0,v1} registers; stable while out_valid high and out_ready low (back-pressure holds indefinitely).
REQ-018 Input changes on idata/key after the accept edge have no effect on the running block.
REQ-019 in_valid while busy is ignored (in_ready low); no queuing, no drop flag.
REQ-020 Handshake completing in DONE returns to IDLE; a new block is accepted at the earliest on the following edge (no same-cycle out/in overlap).
REQ-021 Decryption of the output of tea_round applied ROUNDS times with the matching sum schedule recovers the original plaintext bit-exactly.

Reset
REQ-022 rst asserted: state=IDLE, counter=0, v0/v1/sum/key registers=0, in_ready=1 after reset release, out_valid=0, odata=0, busy=0.
REQ-023 rst mid-RUN or mid-DONE aborts the block immediately; no partial result ever asserts out_valid.
REQ-024 While rst is high, in_ready=0.

Structure
REQ-025 Shared package tea_pkg holds DELTA=32'h9E3779B9, default ROUNDS, state enum, and the 64-bit data / 128-bit key typedefs; tea_round shall use the same package.
REQ-026 One combinational sub-module tea_inv_round (idata, sum, key -> odata) implements REQ-014 for one cycle; tea_decrypt instantiates it once and owns all registers.
REQ-027 Counter width $clog2(ROUNDS)+1; no combinational path from in_valid to out_valid or from out_ready to in_ready.

Verification
REQ-028 Known vector: key=0, idata=64'h41EA3A0A_94BAA940 -> odata=64'h0 with out_valid rising exactly 32 cycles after accept.
REQ-029 Round-trip: 100 random {plaintext,key} encrypted by a 32-round chain of tea_round (sum stepping by DELTA from DELTA) -> tea_decrypt odata equals plaintext for every vector.
REQ-030 Back-pressure: out_ready=0 for 10 cycles after out_valid -> odata, out_valid stable, in_ready=0; release -> one-cycle handshake, IDLE next edge.
REQ-031 Busy rejection: in_valid pulsed with different idata at cycles 5 and 20 of RUN -> ignored, result matches the originally accepted block.
REQ-032 Reset mid-operation: rst asserted at RUN cycle 16 -> all outputs at reset values same cycle (async); next accepted block decrypts correctly with full 32-cycle latency.
REQ-033 Back-to-back: in_valid held high, out_ready held high -> blocks accepted every ROUNDS+2 cycles, each odata correct.
